regfile_debug_port: RTL
=======================

# regfile_debug_port

Debug-side initiator for the 32x32 RV32 register file. It accepts read, write, clear-all and dump commands over a valid/ready channel while the core is halted, and drives the register file's read port 1 and write port. It returns results over a valid/ready response channel. The block sits between the debug transport and the top-level register-file port mux; `busy` selects this block's ports in that mux.

## Interface
Parameters:
- `XLEN`, 32: register and data width.
- `NREGS`, 32: register count; the address width is $clog2(NREGS).

Ports:
- `clk`  in  1: clock; the only clock.
- `reset`  in  1: synchronous, active-high reset.
- `core_halted`  in  1: core is halted; this gates command acceptance.
- `cmd_valid`  in  1: command valid.
- `cmd_ready`  out  1: command accepted when high together with `cmd_valid`.
- `cmd_op`  in  2: 0 READ, 1 WRITE, 2 CLEAR, 3 DUMP.
- `cmd_addr`  in  5: register index; ignored for CLEAR and DUMP.
- `cmd_wdata`  in  XLEN: write data for WRITE.
- `rsp_valid`  out  1: response valid.
- `rsp_ready`  in  1: response consumed.
- `rsp_addr`  out  5: register index of the response.
- `rsp_data`  out  XLEN: read data; for WRITE, the written value; for CLEAR, 0.
- `rsp_last`  out  1: final beat of the command.
- `busy`  out  1: state != IDLE; the top-level mux gives the register-file ports to this block.
- `rf_a1`  out  5: register-file read address 1.
- `rf_rd1`  in  XLEN: register-file read data 1; combinational from `rf_a1`.
- `rf_we`  out  1: register-file write enable.
- `rf_a3`  out  5: register-file write address.
- `rf_wd`  out  XLEN: register-file write data.

## Operation
- FSM states: IDLE, READ, WRITE, CLEAR, DUMP_RD, DUMP_WAIT, RESP.
- `cmd_ready` = (state==IDLE) && `core_halted`.
- On acceptance, the block latches op, addr and wdata and moves to the state for that op.
- READ:
  - Drives `rf_a1`=addr and registers `rf_rd1` into `rsp_data`.
  - Sets `rsp_addr`=addr and `rsp_last`=1, then moves to RESP.
  - addr 0 returns 0, because the register file hardwires x0.
- WRITE:
  - Asserts `rf_we` for exactly one cycle with `rf_a3`=addr and `rf_wd`=wdata, then moves to RESP with `rsp_data`=wdata.
  - addr 0 still pulses `rf_we`; the register file discards it, and the response is still returned.
- CLEAR:
  - A 5-bit counter starts at 1 and asserts `rf_we` with `rf_wd`=0 and `rf_a3`=cnt for cnt=1..31, one register per cycle.
  - After cnt==31, the block moves to RESP with `rsp_addr`=31, `rsp_data`=0 and `rsp_last`=1.
- DUMP:
  - The counter starts at 0.
  - DUMP_RD drives `rf_a1`=cnt, loads `rsp_data`/`rsp_addr`, sets `rsp_last`=(cnt==31) and `rsp_valid`=1, then moves to DUMP_WAIT.
  - DUMP_WAIT holds until `rsp_ready`. Then, if cnt==31, it moves to IDLE; otherwise it increments cnt and moves to DUMP_RD.
- RESP: holds `rsp_valid` until `rsp_ready`, then moves to IDLE.
- `rsp_*` stay stable while `rsp_valid` && !`rsp_ready`.
- `core_halted` falling mid-command does not abort the command; the command completes, and `busy` keeps the core owner stalled.
- When idle, `rf_we`=0, and `rf_a1`/`rf_a3`/`rf_wd`=0.
- `rf_we` is combinational from state and is forced 0 whenever `reset`=1.

## Timing
- Command handshake at edge N means the command is accepted at that edge.
- READ: `rf_a1` is valid during cycle N+1; `rsp_valid` goes high at N+2.
- WRITE: `rf_we` is high during cycle N+1, so the register is updated at the end of N+1; `rsp_valid` goes high at N+2.
- CLEAR: `rf_we` is high during cycles N+1..N+31; `rsp_valid` goes high at N+32.
- DUMP: the first beat is valid at N+2. After each beat handshake, the next beat is valid 2 cycles later (one bubble). A full dump takes at least 64 cycles.
- Back-to-back commands: the next `cmd_ready` goes high the cycle after the final response handshake.
- Reset values: state=IDLE, cnt=0, `rsp_valid`=0, `rsp_last`=0, `rsp_addr`=0, `rsp_data`=0, `busy`=0, `rf_we`=0.
- Reset mid-operation: the block returns to IDLE at the next edge and any pending response is dropped. A partially completed CLEAR leaves the registers partially cleared.

## Structure
- Shared package `kianv_dbg_pkg`: the `dbg_op_t` enum (READ/WRITE/CLEAR/DUMP) and the `dbg_state_t` enum.
- A single flat module; no sub-module. The counter and response register are inline.

## Test plan
- WRITE x5=0xDEADBEEF, then READ x5 → response {addr 5, data 0xDEADBEEF, last 1}; `rf_we` high for exactly 1 cycle.
- WRITE x0=0x1234, then READ x0 → the WRITE response returns data 0x1234; the READ returns 0.
- Preload x1..x31=index*0x11, then CLEAR → `rf_we` high 31 consecutive cycles; afterwards, DUMP returns 32 beats, all data 0, with `rsp_last` only on addr 31.
- DUMP with `rsp_ready` randomly stalled → beats arrive in order 0..31, `rsp_*` stay stable during stalls, and each value matches the preload.
- `cmd_valid` with `core_halted`=0 → `cmd_ready`=0 and no register-file activity; raise `core_halted` → command accepted next edge.
- Assert `reset` at cycle 10 of a CLEAR → `rf_we`=0 that cycle, no response, `busy`=0 after the edge, x1..x9 cleared, and x10..x31 unchanged.

Source files
------------

// File: rtl/kianv_dbg_pkg.sv
// Shared types for the debug-side register-file initiator.
package kianv_dbg_pkg;

   typedef enum logic [1:0] {
      OP_READ  = 2'd0,
      OP_WRITE = 2'd1,
      OP_CLEAR = 2'd2,
      OP_DUMP  = 2'd3
   } dbg_op_t;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_READ      = 3'd1,
      ST_WRITE     = 3'd2,
      ST_CLEAR     = 3'd3,
      ST_DUMP_RD   = 3'd4,
      ST_DUMP_WAIT = 3'd5,
      ST_RESP      = 3'd6
   } dbg_state_t;

endpackage

// File: rtl/regfile_debug_port.sv
// Debug command initiator: drives register-file read port 1 and the write port
// while the core is halted, returning results on a valid/ready response channel.
module regfile_debug_port
   import kianv_dbg_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   localparam int AW   = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            core_halted,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic [1:0]      cmd_op,
   input  logic [AW-1:0]   cmd_addr,
   input  logic [XLEN-1:0] cmd_wdata,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [AW-1:0]   rsp_addr,
   output logic [XLEN-1:0] rsp_data,
   output logic            rsp_last,
   output logic            busy,
   output logic [AW-1:0]   rf_a1,
   input  logic [XLEN-1:0] rf_rd1,
   output logic            rf_we,
   output logic [AW-1:0]   rf_a3,
   output logic [XLEN-1:0] rf_wd
);

   localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

   dbg_state_t state, next_state;
   logic [AW-1:0]   cnt;
   logic [AW-1:0]   op_addr;
   logic [XLEN-1:0] op_wdata;
   logic            accept;

   assign accept = cmd_valid && cmd_ready;

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      cmd_ready  = 1'b0;
      busy       = (state != ST_IDLE);
      rf_we      = 1'b0;
      rf_a1      = '0;
      rf_a3      = '0;
      rf_wd      = '0;
      case (state)
         ST_IDLE: begin
            cmd_ready = core_halted;
            if (cmd_valid && core_halted) begin
               case (dbg_op_t'(cmd_op))
                  OP_READ:  next_state = ST_READ;
                  OP_WRITE: next_state = ST_WRITE;
                  OP_CLEAR: next_state = ST_CLEAR;
                  default:  next_state = ST_DUMP_RD;
               endcase
            end
         end
         ST_READ: begin
            rf_a1      = op_addr;
            next_state = ST_RESP;
         end
         ST_WRITE: begin
            rf_we      = 1'b1;
            rf_a3      = op_addr;
            rf_wd      = op_wdata;
            next_state = ST_RESP;
         end
         ST_CLEAR: begin
            rf_we = 1'b1;
            rf_a3 = cnt;
            if (cnt == LAST) next_state = ST_RESP;
         end
         ST_DUMP_RD: begin
            rf_a1      = cnt;
            next_state = ST_DUMP_WAIT;
         end
         ST_DUMP_WAIT: begin
            if (rsp_ready) next_state = (cnt == LAST) ? ST_IDLE : ST_DUMP_RD;
         end
         ST_RESP: begin
            if (rsp_ready) next_state = ST_IDLE;
         end
         default: next_state = ST_IDLE;
      endcase
      // A write strobe must never escape while the block is being reset.
      if (reset) rf_we = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         op_addr  <= cmd_addr;
         op_wdata <= cmd_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt       <= '0;
         rsp_valid <= 1'b0;
         rsp_last  <= 1'b0;
         rsp_addr  <= '0;
         rsp_data  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) cnt <= (dbg_op_t'(cmd_op) == OP_CLEAR) ? AW'(1) : '0;
            end
            ST_READ: begin
               rsp_data  <= rf_rd1;
               rsp_addr  <= op_addr;
               rsp_last  <= 1'b1;
               rsp_valid <= 1'b1;
            end
            ST_WRITE: begin
               rsp_data  <= op_wdata;
               rsp_addr  <= op_addr;
               rsp_last  <= 1'b1;
               rsp_valid <= 1'b1;
            end
            ST_CLEAR: begin
               if (cnt == LAST) begin
                  rsp_data  <= '0;
                  rsp_addr  <= LAST;
                  rsp_last  <= 1'b1;
                  rsp_valid <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_DUMP_RD: begin
               rsp_data  <= rf_rd1;
               rsp_addr  <= cnt;
               rsp_last  <= (cnt == LAST);
               rsp_valid <= 1'b1;
            end
            ST_DUMP_WAIT: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  if (cnt != LAST) cnt <= cnt + 1'b1;
               end
            end
            ST_RESP: begin
               if (rsp_ready) rsp_valid <= 1'b0;
            end
            default: rsp_valid <= 1'b0;
         endcase
      end
   end

endmodule
